// File: rtl/rdcla_share_arb.sv
// Round-robin front end that time-shares one pipelined adder between two requesters and routes
// each sum/carry back to its owner a fixed LAT+2 cycles after the handshake.
module rdcla_share_arb #(
  parameter int unsigned W   = 32,
  parameter int unsigned LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         add_vld,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_sum,
  output logic         rsp0_cout,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_sum,
  output logic         rsp1_cout,
  output logic [3:0]   inflight
);

  logic         r_prio;
  logic [W-1:0] r_add_a, r_add_b;
  logic         r_add_cin;
  logic [LAT:0] r_tag_vld, r_tag_id;
  logic         r_rsp0_valid, r_rsp1_valid;
  logic [W-1:0] r_rsp0_sum, r_rsp1_sum;
  logic         r_rsp0_cout, r_rsp1_cout;
  logic [3:0]   r_inflight;

  logic w_gnt0, w_gnt1, w_xfer, w_id, w_dec;

  // r_prio names the requester that wins when both are valid; grants are masked during reset.
  assign w_gnt0 = rst_n & req0_valid & (~req1_valid | ~r_prio);
  assign w_gnt1 = rst_n & req1_valid & (~req0_valid | r_prio);
  assign w_xfer = w_gnt0 | w_gnt1;
  assign w_id   = w_gnt1;
  assign w_dec  = r_rsp0_valid | r_rsp1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio    <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
    end else if (w_xfer) begin
      r_prio    <= ~w_id;
      r_add_a   <= w_id ? req1_a : req0_a;
      r_add_b   <= w_id ? req1_b : req0_b;
      r_add_cin <= w_id ? req1_cin : req0_cin;
    end
  end

  // Stage 0 doubles as the issue strobe; stage LAT lines up with add_sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[LAT-1:0], w_xfer};
      r_tag_id  <= {r_tag_id[LAT-1:0], w_id};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_sum   <= '0;
      r_rsp1_sum   <= '0;
      r_rsp0_cout  <= 1'b0;
      r_rsp1_cout  <= 1'b0;
    end else begin
      r_rsp0_valid <= r_tag_vld[LAT] & ~r_tag_id[LAT];
      r_rsp1_valid <= r_tag_vld[LAT] & r_tag_id[LAT];
      if (r_tag_vld[LAT] && !r_tag_id[LAT]) begin
        r_rsp0_sum  <= add_sum;
        r_rsp0_cout <= add_cout;
      end
      if (r_tag_vld[LAT] && r_tag_id[LAT]) begin
        r_rsp1_sum  <= add_sum;
        r_rsp1_cout <= add_cout;
      end
    end
  end

  // An add stops counting once its response pulse has actually been presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= r_inflight + {3'b000, w_xfer} - {3'b000, w_dec};
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign add_vld    = r_tag_vld[0];
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_cin    = r_add_cin;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_sum   = r_rsp0_sum;
  assign rsp0_cout  = r_rsp0_cout;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_sum   = r_rsp1_sum;
  assign rsp1_cout  = r_rsp1_cout;
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_rdcla_share_arb.sv
// Bench: three arbiters (LAT=1,4,8) share one request stream, each fronting a behavioural adder;
// a transaction-history model predicts grants, response timing, owners and sums.
module tb_rdcla_share_arb;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         v0 = 1'b0, v1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic         rdy0 [3], rdy1 [3], add_vld [3], add_cin [3], add_cout [3];
  logic [W-1:0] add_a [3], add_b [3], add_sum [3];
  logic         rsp0v [3], rsp1v [3], rsp0c [3], rsp1c [3];
  logic [W-1:0] rsp0s [3], rsp1s [3];
  logic [3:0]   infl [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    logic [W:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= {1'b0, add_a[g]} + {1'b0, add_b[g]} + {{W{1'b0}}, add_cin[g]};
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign add_sum[g]  = pipe[L-1][W-1:0];
    assign add_cout[g] = pipe[L-1][W];

    rdcla_share_arb #(.W(W), .LAT(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v0),
      .req0_ready (rdy0[g]),
      .req0_a     (a0),
      .req0_b     (b0),
      .req0_cin   (c0),
      .req1_valid (v1),
      .req1_ready (rdy1[g]),
      .req1_a     (a1),
      .req1_b     (b1),
      .req1_cin   (c1),
      .add_vld    (add_vld[g]),
      .add_a      (add_a[g]),
      .add_b      (add_b[g]),
      .add_cin    (add_cin[g]),
      .add_sum    (add_sum[g]),
      .add_cout   (add_cout[g]),
      .rsp0_valid (rsp0v[g]),
      .rsp0_sum   (rsp0s[g]),
      .rsp0_cout  (rsp0c[g]),
      .rsp1_valid (rsp1v[g]),
      .rsp1_sum   (rsp1s[g]),
      .rsp1_cout  (rsp1c[g]),
      .inflight   (infl[g])
    );
  end

  typedef struct {
    int           h;
    logic         id;
    logic [W-1:0] s;
    logic         c;
  } xfer_t;

  xfer_t        hist [$];
  int           rd [3];
  int           inf [3];
  logic [W-1:0] ls [3][2];
  logic         lc [3][2];
  logic         prio_m = 1'b0;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           peak = 0;
  logic         obs_r0, obs_r1;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then move past the rise.
  task automatic step();
    logic         has, win, pv0, pv1;
    logic [W:0]   full;
    xfer_t        x;
    @(negedge clk);
    if (!rst_n) begin
      prio_m = 1'b0;
      for (int d = 0; d < 3; d++) begin
        rd[d]  = hist.size();
        inf[d] = 0;
        for (int r = 0; r < 2; r++) begin
          ls[d][r] = '0;
          lc[d][r] = 1'b0;
        end
      end
    end
    has = rst_n && (v0 || v1);
    win = (v0 && v1) ? prio_m : v1;
    obs_r0 = rdy0[1];
    obs_r1 = rdy1[1];
    for (int d = 0; d < 3; d++) begin
      string sfx;
      sfx = $sformatf("[LAT%0d]", lat_of(d));
      chk({"req0_ready", sfx}, 64'(rdy0[d]), 64'(has && !win));
      chk({"req1_ready", sfx}, 64'(rdy1[d]), 64'(has && win));
      pv0 = 1'b0;
      pv1 = 1'b0;
      if (rd[d] < hist.size() && hist[rd[d]].h + lat_of(d) + 2 == cyc) begin
        x = hist[rd[d]];
        ls[d][x.id] = x.s;
        lc[d][x.id] = x.c;
        pv0 = !x.id;
        pv1 = x.id;
        rd[d]++;
      end
      chk({"rsp0_valid", sfx}, 64'(rsp0v[d]), 64'(pv0));
      chk({"rsp1_valid", sfx}, 64'(rsp1v[d]), 64'(pv1));
      chk({"rsp0_sum", sfx}, 64'(rsp0s[d]), 64'(ls[d][0]));
      chk({"rsp0_cout", sfx}, 64'(rsp0c[d]), 64'(lc[d][0]));
      chk({"rsp1_sum", sfx}, 64'(rsp1s[d]), 64'(ls[d][1]));
      chk({"rsp1_cout", sfx}, 64'(rsp1c[d]), 64'(lc[d][1]));
      chk({"inflight", sfx}, 64'(infl[d]), 64'(inf[d]));
      inf[d] += (has ? 1 : 0) - ((pv0 || pv1) ? 1 : 0);
    end
    if (32'(infl[1]) > peak) peak = 32'(infl[1]);
    if (has) begin
      full = win ? ({1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, c1})
                 : ({1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, c0});
      x.h  = cyc;
      x.id = win;
      x.s  = full[W-1:0];
      x.c  = full[W];
      hist.push_back(x);
      prio_m = !win;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    v0 = 1'b0;
    v1 = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rnd_ops();
    a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
    a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
  endtask

  initial begin
    // Reset with both requesters valid: ready must stay low.
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;

    // Sole requester 0, six back-to-back adds, sums 1..6.
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; a0 = W'(i); b0 = 32'd1; c0 = 1'b0; v1 = 1'b0;
      step();
    end
    idle(12);

    // Continuous contention straight out of reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1; v1 = 1'b1; rnd_ops();
      step();
    end
    idle(12);
    chk("inflight_peak[LAT4]", 64'(peak), 64'd6);

    // Carry propagation on both requesters.
    v0 = 1'b1; a0 = 32'h8000_0000; b0 = 32'h8000_0000; c0 = 1'b0;
    v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0000; c1 = 1'b1;
    step();
    v0 = 1'b0;
    step();
    idle(12);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("carry_rsp0_sum[%0d]", d), 64'(rsp0s[d]), 64'd0);
      chk($sformatf("carry_rsp0_cout[%0d]", d), 64'(rsp0c[d]), 64'd1);
      chk($sformatf("carry_rsp1_sum[%0d]", d), 64'(rsp1s[d]), 64'd0);
      chk($sformatf("carry_rsp1_cout[%0d]", d), 64'(rsp1c[d]), 64'd1);
    end

    // Priority stability across idle gaps.
    v0 = 1'b1; v1 = 1'b0; rnd_ops();
    step();
    v1 = 1'b1;
    step();
    chk("prio_r1_after_sole_r0", 64'(obs_r1), 64'd1);
    idle(3);
    v0 = 1'b1; v1 = 1'b1; rnd_ops();
    step();
    chk("prio_r0_after_idle", 64'(obs_r0), 64'd1);
    idle(12);

    // Reset while three adds are in flight.
    for (int i = 0; i < 3; i++) begin
      v0 = 1'b1; v1 = 1'b0; rnd_ops();
      step();
    end
    idle(1);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("inflight_after_reset[LAT4]", 64'(infl[1]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      v0 = 1'b0; v1 = 1'b1; rnd_ops();
      step();
    end
    idle(12);

    // Random traffic, including valids dropped while waiting.
    for (int i = 0; i < 80; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      rnd_ops();
      step();
    end
    idle(14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
